// File: rtl/noc_pkg.sv
// Shared constants and types for the PE-side NoC endpoint: flit geometry,
// counter widths and the TX skid-buffer state encoding.
package noc_pkg;

   localparam int NocDataWidth    = 32;
   localparam int NocAddrWidth    = 3;
   localparam int NocPayloadWidth = NocDataWidth - NocAddrWidth;
   localparam int NocDestMsb      = NocDataWidth - 1;
   localparam int NocDestLsb      = NocDataWidth - NocAddrWidth;

   localparam int TxCountWidth    = 16;
   localparam int RxCountWidth    = 16;
   localparam int DropCountWidth  = 8;

   typedef enum logic [1:0] {
      TxEmpty = 2'd0,
      TxMain  = 2'd1,
      TxFull  = 2'd2
   } txState_e;

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Pointers carry one extra wrap bit
// so full and empty can be told apart; read data is forced to zero while empty.
module noc_sync_fifo #(
   parameter int Width = 29,
   parameter int Depth = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_wrEn,
   input  logic [Width-1:0] i_wrData,
   input  logic             i_rdEn,
   output logic [Width-1:0] o_rdData,
   output logic             o_empty,
   output logic             o_full
);

   localparam int AddrBits = $clog2(Depth);
   localparam logic [AddrBits:0] PtrOne = {{AddrBits{1'b0}}, 1'b1};

   logic [Width-1:0]  mem [Depth];
   logic [AddrBits:0] wrPtr;
   logic [AddrBits:0] rdPtr;
   logic              doWrite;
   logic              doRead;

   assign o_empty  = (wrPtr == rdPtr);
   assign o_full   = (wrPtr[AddrBits] != rdPtr[AddrBits]) &&
                     (wrPtr[AddrBits-1:0] == rdPtr[AddrBits-1:0]);
   assign doWrite  = i_wrEn && !o_full;
   assign doRead   = i_rdEn && !o_empty;
   assign o_rdData = o_empty ? '0 : mem[rdPtr[AddrBits-1:0]];

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doWrite) wrPtr <= wrPtr + PtrOne;
         if (doRead)  rdPtr <= rdPtr + PtrOne;
      end
   end

   always_ff @(posedge i_clk) begin
      if (doWrite) mem[wrPtr[AddrBits-1:0]] <= i_wrData;
   end

endmodule

// File: rtl/noc_pe_interface.sv
// PE-side endpoint of the NoC: TX packs {dest, payload} through a 2-entry skid
// buffer, RX filters on MyAddr into a FWFT FIFO, plus traffic/misroute counters.
module noc_pe_interface
   import noc_pkg::*;
#(
   parameter int DataWidth = NocDataWidth,
   parameter int AddrWidth = NocAddrWidth,
   parameter int MyAddr    = 0,
   parameter int RxDepth   = 4
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic [DataWidth-AddrWidth-1:0] i_pe_data,
   input  logic [AddrWidth-1:0]           i_pe_dest,
   input  logic                           i_pe_valid,
   output logic                           o_pe_ready,
   output logic [DataWidth-1:0]           o_noc_data,
   output logic                           o_noc_data_valid,
   input  logic                           i_noc_data_ready,
   input  logic [DataWidth-1:0]           i_noc_data,
   input  logic                           i_noc_data_valid,
   output logic                           o_noc_data_ready,
   output logic [DataWidth-AddrWidth-1:0] o_pe_data,
   output logic                           o_pe_valid,
   input  logic                           i_pe_ready,
   output logic [TxCountWidth-1:0]        o_tx_count,
   output logic [RxCountWidth-1:0]        o_rx_count,
   output logic [DropCountWidth-1:0]      o_drop_count,
   output logic [1:0]                     o_tx_state
);

   localparam int PayloadWidth = DataWidth - AddrWidth;
   localparam logic [AddrWidth-1:0] MyDest = AddrWidth'(MyAddr);

   // Every channel transfers on a rising edge where valid && ready; valid never
   // looks at ready, and data/valid stay put until that transfer happens.
   txState_e             txState, txNext;
   logic [DataWidth-1:0] mainData, skidData, txFlit;
   logic                 txAccept, txTake;
   logic                 loadMainIn, loadMainSkid, loadSkid;

   assign txFlit           = {i_pe_dest, i_pe_data};
   assign o_pe_ready       = (txState != TxFull);
   assign o_noc_data_valid = (txState != TxEmpty);
   assign o_noc_data       = mainData;
   assign o_tx_state       = txState;
   assign txAccept         = i_pe_valid && o_pe_ready;
   assign txTake           = o_noc_data_valid && i_noc_data_ready;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) txState <= TxEmpty;
      else          txState <= txNext;
   end

   always_comb begin
      txNext       = txState;
      loadMainIn   = 1'b0;
      loadMainSkid = 1'b0;
      loadSkid     = 1'b0;
      case (txState)
         TxEmpty: if (txAccept) begin
            txNext     = TxMain;
            loadMainIn = 1'b1;
         end
         TxMain: begin
            if (txAccept && txTake) begin
               loadMainIn = 1'b1;
            end else if (txTake) begin
               txNext = TxEmpty;
            end else if (txAccept) begin
               txNext   = TxFull;
               loadSkid = 1'b1;
            end
         end
         TxFull: if (txTake) begin
            txNext       = TxMain;
            loadMainSkid = 1'b1;
         end
         default: txNext = TxEmpty;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         mainData <= '0;
         skidData <= '0;
      end else begin
         if (loadMainIn)        mainData <= txFlit;
         else if (loadMainSkid) mainData <= skidData;
         if (loadSkid)          skidData <= txFlit;
      end
   end

   // RX: flits for other PEs are still consumed so the switch port never stalls on them.
   logic rxFull, rxEmpty, rxAccept, rxMatch, rxWrite, rxDrop;

   assign o_noc_data_ready = !rxFull;
   assign o_pe_valid       = !rxEmpty;
   assign rxAccept         = i_noc_data_valid && o_noc_data_ready;
   assign rxMatch          = (i_noc_data[DataWidth-1 -: AddrWidth] == MyDest);
   assign rxWrite          = rxAccept && rxMatch;
   assign rxDrop           = rxAccept && !rxMatch;

   noc_sync_fifo #(
      .Width (PayloadWidth),
      .Depth (RxDepth)
   ) rxFifo (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_wrEn   (rxWrite),
      .i_wrData (i_noc_data[PayloadWidth-1:0]),
      .i_rdEn   (i_pe_ready),
      .o_rdData (o_pe_data),
      .o_empty  (rxEmpty),
      .o_full   (rxFull)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_tx_count   <= '0;
         o_rx_count   <= '0;
         o_drop_count <= '0;
      end else begin
         if (txTake)                   o_tx_count <= o_tx_count + TxCountWidth'(1);
         if (o_pe_valid && i_pe_ready) o_rx_count <= o_rx_count + RxCountWidth'(1);
         if (rxDrop && (o_drop_count != '1))
            o_drop_count <= o_drop_count + DropCountWidth'(1);
      end
   end

endmodule

// File: tb/tb_noc_pe_interface.sv
// Directed bench for noc_pe_interface (MyAddr=2): a per-cycle vector table for
// basic TX/RX traffic plus hand-written backpressure, full, saturation and reset sequences.
module tb_noc_pe_interface;

   logic        clk;
   logic        rstN;
   logic [28:0] peData;
   logic [2:0]  peDest;
   logic        peValid;
   logic        peReadyOut;
   logic [31:0] nocDataOut;
   logic        nocValidOut;
   logic        nocReady;
   logic [31:0] nocIn;
   logic        nocInValid;
   logic        nocReadyOut;
   logic [28:0] peDataOut;
   logic        peValidOut;
   logic        peReadyIn;
   logic [15:0] txCount;
   logic [15:0] rxCount;
   logic [7:0]  dropCount;
   logic [1:0]  txState;

   int compared   = 0;
   int mismatched = 0;
   logic [28:0] expQ[$];

   noc_pe_interface #(
      .DataWidth (32),
      .AddrWidth (3),
      .MyAddr    (2),
      .RxDepth   (4)
   ) dut (
      .i_clk            (clk),
      .i_reset          (rstN),
      .i_pe_data        (peData),
      .i_pe_dest        (peDest),
      .i_pe_valid       (peValid),
      .o_pe_ready       (peReadyOut),
      .o_noc_data       (nocDataOut),
      .o_noc_data_valid (nocValidOut),
      .i_noc_data_ready (nocReady),
      .i_noc_data       (nocIn),
      .i_noc_data_valid (nocInValid),
      .o_noc_data_ready (nocReadyOut),
      .o_pe_data        (peDataOut),
      .o_pe_valid       (peValidOut),
      .i_pe_ready       (peReadyIn),
      .o_tx_count       (txCount),
      .o_rx_count       (rxCount),
      .o_drop_count     (dropCount),
      .o_tx_state       (txState)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected test completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [28:0] peData;
      logic [2:0]  peDest;
      logic        peValid;
      logic        nocReady;
      logic [31:0] nocIn;
      logic        nocInValid;
      logic        peReadyIn;
      logic        expNocValid;
      logic [31:0] expNocData;
      logic        expPeValid;
      logic [28:0] expPeData;
      logic [15:0] expTx;
      logic [15:0] expRx;
      logic [7:0]  expDrop;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idleInputs();
      peData     = '0;
      peDest     = '0;
      peValid    = 1'b0;
      nocReady   = 1'b0;
      nocIn      = '0;
      nocInValid = 1'b0;
      peReadyIn  = 1'b0;
   endtask

   task automatic checkResetOutputs(input string tag);
      check({tag, " pe_ready"},   {31'd0, peReadyOut}, 32'd1);
      check({tag, " noc_ready"},  {31'd0, nocReadyOut}, 32'd1);
      check({tag, " noc_valid"},  {31'd0, nocValidOut}, 32'd0);
      check({tag, " pe_valid"},   {31'd0, peValidOut}, 32'd0);
      check({tag, " noc_data"},   nocDataOut, 32'd0);
      check({tag, " pe_data"},    {3'd0, peDataOut}, 32'd0);
      check({tag, " tx_count"},   {16'd0, txCount}, 32'd0);
      check({tag, " rx_count"},   {16'd0, rxCount}, 32'd0);
      check({tag, " drop_count"}, {24'd0, dropCount}, 32'd0);
      check({tag, " tx_state"},   {30'd0, txState}, 32'd0);
   endtask

   initial begin
      bit pending;
      logic [28:0] head;

      // pe_data, dest, pe_valid, noc_ready, noc_in, in_valid, pe_ready |
      // exp noc_valid, noc_data, pe_valid, pe_data, tx, rx, drop
      vecs[0] = '{29'h0,        3'd0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 29'h0,        16'd0, 16'd0, 8'd0};
      vecs[1] = '{29'h0ABCDEF,  3'd5, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA0ABCDEF, 1'b0, 29'h0,        16'd0, 16'd0, 8'd0};
      vecs[2] = '{29'h0,        3'd0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 29'h0,        16'd1, 16'd0, 8'd0};
      vecs[3] = '{29'h0,        3'd0, 1'b0, 1'b1, 32'h50000123, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 29'h10000123, 16'd1, 16'd0, 8'd0};
      vecs[4] = '{29'h0,        3'd0, 1'b0, 1'b1, 32'h60000001, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 29'h0,        16'd1, 16'd1, 8'd1};
      vecs[5] = '{29'h1,        3'd2, 1'b1, 1'b1, 32'h40000007, 1'b1, 1'b1, 1'b1, 32'h40000001, 1'b1, 29'h7,        16'd1, 16'd1, 8'd1};
      vecs[6] = '{29'h2,        3'd7, 1'b1, 1'b1, 32'h40000008, 1'b1, 1'b1, 1'b1, 32'hE0000002, 1'b1, 29'h8,        16'd2, 16'd2, 8'd1};
      vecs[7] = '{29'h0,        3'd0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 29'h0,        16'd3, 16'd3, 8'd1};

      idleInputs();
      rstN = 1'b0;
      repeat (2) tick();
      checkResetOutputs("reset");
      rstN = 1'b1;

      // table-driven basic traffic
      for (int i = 0; i < 8; i++) begin
         peData     = vecs[i].peData;
         peDest     = vecs[i].peDest;
         peValid    = vecs[i].peValid;
         nocReady   = vecs[i].nocReady;
         nocIn      = vecs[i].nocIn;
         nocInValid = vecs[i].nocInValid;
         peReadyIn  = vecs[i].peReadyIn;
         tick();
         check($sformatf("vec%0d noc_valid", i), {31'd0, nocValidOut}, {31'd0, vecs[i].expNocValid});
         if (vecs[i].expNocValid)
            check($sformatf("vec%0d noc_data", i), nocDataOut, vecs[i].expNocData);
         check($sformatf("vec%0d pe_valid", i), {31'd0, peValidOut}, {31'd0, vecs[i].expPeValid});
         if (vecs[i].expPeValid)
            check($sformatf("vec%0d pe_data", i), {3'd0, peDataOut}, {3'd0, vecs[i].expPeData});
         check($sformatf("vec%0d pe_ready", i), {31'd0, peReadyOut}, 32'd1);
         check($sformatf("vec%0d noc_ready", i), {31'd0, nocReadyOut}, 32'd1);
         check($sformatf("vec%0d tx_count", i), {16'd0, txCount}, {16'd0, vecs[i].expTx});
         check($sformatf("vec%0d rx_count", i), {16'd0, rxCount}, {16'd0, vecs[i].expRx});
         check($sformatf("vec%0d drop_count", i), {24'd0, dropCount}, {24'd0, vecs[i].expDrop});
      end
      idleInputs();

      // TX backpressure: three flits offered while the switch stalls
      nocReady = 1'b0;
      peDest   = 3'd1;
      peValid  = 1'b1;
      peData   = 29'h11;
      tick();
      check("bp A main data", nocDataOut, 32'h20000011);
      check("bp A pe_ready", {31'd0, peReadyOut}, 32'd1);
      check("bp A state", {30'd0, txState}, 32'd1);
      peData = 29'h22;
      tick();
      check("bp B pe_ready", {31'd0, peReadyOut}, 32'd0);
      check("bp B state", {30'd0, txState}, 32'd2);
      check("bp B main data", nocDataOut, 32'h20000011);
      peData = 29'h33;
      tick();
      check("bp C blocked pe_ready", {31'd0, peReadyOut}, 32'd0);
      check("bp C blocked data", nocDataOut, 32'h20000011);
      check("bp C blocked tx_count", {16'd0, txCount}, 32'd3);
      nocReady = 1'b1;
      tick();
      check("bp out B data", nocDataOut, 32'h20000022);
      check("bp out B valid", {31'd0, nocValidOut}, 32'd1);
      check("bp out B pe_ready", {31'd0, peReadyOut}, 32'd1);
      check("bp out B tx_count", {16'd0, txCount}, 32'd4);
      tick();
      check("bp out C data", nocDataOut, 32'h20000033);
      check("bp out C tx_count", {16'd0, txCount}, 32'd5);
      peValid = 1'b0;
      tick();
      check("bp drained valid", {31'd0, nocValidOut}, 32'd0);
      check("bp drained tx_count", {16'd0, txCount}, 32'd6);
      check("bp drained state", {30'd0, txState}, 32'd0);
      nocReady = 1'b0;

      // RX full: four flits fill the FIFO, the fifth waits for space
      peReadyIn  = 1'b0;
      nocInValid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         nocIn = 32'h40000100 + 32'(k);
         expQ.push_back(29'h100 + 29'(k));
         tick();
      end
      check("full noc_ready", {31'd0, nocReadyOut}, 32'd0);
      nocIn = 32'h40000104;
      tick();
      check("full still blocked", {31'd0, nocReadyOut}, 32'd0);
      check("full head data", {3'd0, peDataOut}, 32'h100);
      pending   = 1'b1;
      peReadyIn = 1'b1;
      for (int c = 0; c < 20 && (expQ.size() > 0 || pending); c++) begin
         bit acc;
         acc = nocInValid && nocReadyOut;
         if (acc) expQ.push_back(29'h104);
         if (peValidOut) begin
            if (expQ.size() == 0) begin
               check("drain unexpected pe_valid", {31'd0, peValidOut}, 32'd0);
            end else begin
               head = expQ.pop_front();
               check("drain order", {3'd0, peDataOut}, {3'd0, head});
            end
         end
         tick();
         if (acc) begin
            nocInValid = 1'b0;
            pending    = 1'b0;
         end
      end
      check("fifth accepted", {31'd0, pending}, 32'd0);
      check("drain scoreboard empty", expQ.size(), 32'd0);
      check("drain rx_count", {16'd0, rxCount}, 32'd8);
      check("drain pe_valid", {31'd0, peValidOut}, 32'd0);

      // misroute counter saturation
      nocIn      = 32'h60000000;
      nocInValid = 1'b1;
      repeat (253) tick();
      check("drop 254", {24'd0, dropCount}, 32'd254);
      repeat (10) tick();
      check("drop saturated", {24'd0, dropCount}, 32'd255);
      check("drop no write", {31'd0, peValidOut}, 32'd0);
      check("drop rx_count", {16'd0, rxCount}, 32'd8);
      nocInValid = 1'b0;

      // async reset with both paths holding data
      nocReady   = 1'b0;
      peValid    = 1'b1;
      peDest     = 3'd4;
      peData     = 29'h55;
      peReadyIn  = 1'b0;
      nocIn      = 32'h40000AAA;
      nocInValid = 1'b1;
      repeat (2) tick();
      check("busy tx state", {30'd0, txState}, 32'd2);
      check("busy pe_valid", {31'd0, peValidOut}, 32'd1);
      #3;
      rstN = 1'b0;
      #1;
      checkResetOutputs("async reset");
      idleInputs();
      nocReady  = 1'b1;
      peReadyIn = 1'b1;
      tick();
      rstN = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         check($sformatf("post reset %0d noc_valid", c), {31'd0, nocValidOut}, 32'd0);
         check($sformatf("post reset %0d pe_valid", c), {31'd0, peValidOut}, 32'd0);
      end
      check("post reset tx_count", {16'd0, txCount}, 32'd0);
      check("post reset rx_count", {16'd0, rxCount}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
